// File: rtl/bar_graph_renderer.sv
// N-bar spectrum renderer: latches amplitudes on each vsync falling edge,
// tracks per-bar peak-hold/decay and colours each pixel (registered output).
module bar_graph_renderer #(
  parameter int unsigned NUM_BARS = 10,
  parameter int unsigned AMP_W    = 9,
  parameter int unsigned BAR_W    = 53,
  parameter int unsigned GAP      = 10,
  parameter int unsigned X0       = 10,
  parameter int unsigned BASE_Y   = 480,
  parameter int unsigned PEAK_T   = 2,
  parameter int unsigned HOLD_FR  = 30,
  parameter int unsigned DECAY    = 2,
  parameter logic [11:0] BG_RGB   = 12'h008,
  parameter logic [11:0] FG_RGB   = 12'h800,
  parameter logic [11:0] PK_RGB   = 12'hFFF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      VS,
  input  logic                      blank,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [NUM_BARS*AMP_W-1:0] amp_in,
  input  logic [NUM_BARS-1:0]       bar_en,
  input  logic                      peak_en,
  output logic                      frame_tick,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B
);

  localparam int unsigned CW = 11;
  localparam int unsigned HW = (HOLD_FR > 0) ? $clog2(HOLD_FR + 1) : 1;

  logic                         vs_q;
  logic [NUM_BARS-1:0][CW-1:0]  amp_q,  amp_d;
  logic [NUM_BARS-1:0][CW-1:0]  peak_q, peak_d;
  logic [NUM_BARS-1:0][HW-1:0]  hold_q, hold_d;
  logic [11:0]                  rgb_q,  rgb_d;

  logic [CW-1:0] raw, amp_a, dec;
  logic [CW-1:0] x, y, left, top_f, top_p, lo_p;
  logic          col, fill_hit, mark_hit;

  // Falling-edge detect on vsync; suppressed while reset is held.
  assign frame_tick = vs_q & ~VS & ~Reset;

  // Per-bar latch, peak-hold and decay, all evaluated only in the tick cycle.
  always_comb begin : bar_next
    amp_d  = amp_q;
    peak_d = peak_q;
    hold_d = hold_q;
    raw    = '0;
    amp_a  = '0;
    dec    = '0;
    if (frame_tick) begin
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
        raw   = CW'(amp_in[i*AMP_W +: AMP_W]);
        amp_a = !bar_en[i] ? '0 : ((raw > CW'(BASE_Y)) ? CW'(BASE_Y) : raw);
        dec   = (peak_q[i] > CW'(DECAY)) ? peak_q[i] - CW'(DECAY) : '0;
        amp_d[i] = amp_a;
        if (amp_a >= peak_q[i]) begin
          peak_d[i] = amp_a;
          hold_d[i] = HW'(HOLD_FR);
        end else if (hold_q[i] != '0) begin
          hold_d[i] = hold_q[i] - HW'(1);
        end else begin
          peak_d[i] = (dec > amp_a) ? dec : amp_a;
        end
      end
    end
  end

  // Pixel classification from latched state; marker wins over fill.
  always_comb begin : pixel_next
    x        = CW'(DrawX);
    y        = CW'(DrawY);
    left     = '0;
    top_f    = '0;
    top_p    = '0;
    lo_p     = '0;
    col      = 1'b0;
    fill_hit = 1'b0;
    mark_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      left  = CW'(X0 + i * (BAR_W + GAP));
      col   = (x >= left) && (x <= left + CW'(BAR_W - 1));
      top_f = CW'(BASE_Y) - amp_q[i];
      top_p = CW'(BASE_Y) - peak_q[i];
      lo_p  = (top_p >= CW'(PEAK_T)) ? top_p - CW'(PEAK_T) : '0;
      if (col && (amp_q[i] != '0) && (y >= top_f) && (y < CW'(BASE_Y)))
        fill_hit = 1'b1;
      if (col && peak_en && (peak_q[i] != '0) && (y >= lo_p) && (y < top_p))
        mark_hit = 1'b1;
    end
    if (!blank)        rgb_d = '0;
    else if (mark_hit) rgb_d = PK_RGB;
    else if (fill_hit) rgb_d = FG_RGB;
    else               rgb_d = BG_RGB;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q   <= 1'b1;
      amp_q  <= '0;
      peak_q <= '0;
      hold_q <= '0;
      rgb_q  <= '0;
    end else begin
      vs_q   <= VS;
      amp_q  <= amp_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
      rgb_q  <= rgb_d;
    end
  end

  assign VGA_R = rgb_q[11:8];
  assign VGA_G = rgb_q[7:4];
  assign VGA_B = rgb_q[3:0];

endmodule
